// File: rtl/arb_types.sv
// Shared types and constants for the L1-to-memory burst arbiter.
package arb_types;

    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int ADDR_W = 32;
    localparam int BEATS  = LINE_W / BEAT_W;
    localparam int IDX_W  = $clog2(BEATS);
    localparam int OFFS_W = $clog2(LINE_W / 8);

    typedef logic [IDX_W-1:0] beat_idx_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        I_RD = 3'd1,
        D_RD = 3'd2,
        D_WR = 3'd3,
        DONE = 3'd4
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    // Clear the byte-offset bits so the memory always sees a line-aligned address.
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return addr & ~{{(ADDR_W-OFFS_W){1'b0}}, {OFFS_W{1'b1}}};
    endfunction

endpackage

// File: rtl/burst_line_buffer.sv
// One line register shared by fills and writebacks, with the beat counter.
module burst_line_buffer
    import arb_types::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [LINE_W-1:0] line_i,
    input  logic              wr_beat_i,
    input  logic [BEAT_W-1:0] beat_i,
    input  logic              step_i,
    input  logic              clr_i,
    input  beat_idx_t         rd_idx_i,
    output logic [LINE_W-1:0] line_nxt_o,
    output logic [BEAT_W-1:0] rd_beat_o,
    output beat_idx_t         idx_o,
    output logic              last_o
);

    logic [LINE_W-1:0] line_q, line_d;
    beat_idx_t         idx_q, idx_d;

    // Merge the incoming beat into slice k and pick the next counter value.
    always_comb begin
        line_nxt_o = line_q;
        if (wr_beat_i) begin
            line_nxt_o[idx_q*BEAT_W +: BEAT_W] = beat_i;
        end else begin
            line_nxt_o = line_q;
        end
        if (load_i) begin
            line_d = line_i;
        end else begin
            line_d = line_nxt_o;
        end
        if (clr_i) begin
            idx_d = '0;
        end else if (step_i) begin
            idx_d = idx_q + beat_idx_t'(1);
        end else begin
            idx_d = idx_q;
        end
    end

    // Line and beat-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_q <= '0;
            idx_q  <= '0;
        end else begin
            line_q <= line_d;
            idx_q  <= idx_d;
        end
    end

    assign rd_beat_o = line_q[rd_idx_i*BEAT_W +: BEAT_W];
    assign idx_o     = idx_q;
    assign last_o    = (idx_q == beat_idx_t'(BEATS-1));

endmodule

// File: rtl/cache_mem_arbiter_checker.sv
// Protocol checks on the cache-side request interface.
module cache_mem_arbiter_checker (
    input logic clk,
    input logic rst,
    input logic dcache_read,
    input logic dcache_write
);

    // A D-cache read and writeback together is illegal; the write is served.
    always @(posedge clk) begin
        if (rst) begin
            dcache_rw_excl: assert (!(dcache_read && dcache_write))
                else $warning("dcache_read and dcache_write both high; servicing the write");
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I/D line fills and D writebacks onto one 64-bit burst memory port.
module cache_mem_arbiter
    import arb_types::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_read,
    input  logic [ADDR_W-1:0] icache_address,
    output logic [LINE_W-1:0] icache_rdata,
    output logic              icache_resp,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [ADDR_W-1:0] dcache_address,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic [LINE_W-1:0] dcache_rdata,
    output logic              dcache_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [BEAT_W-1:0] pmem_wdata,
    input  logic [BEAT_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t        state_q, state_d;
    grant_t            grant_q, grant_d, last_grant_q, last_grant_d;
    logic              pmem_read_q, pmem_read_d, pmem_write_q, pmem_write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BEAT_W-1:0] wdata_q, wdata_d;
    logic              iresp_q, iresp_d, dresp_q, dresp_d;
    logic [LINE_W-1:0] irdata_q, irdata_d, drdata_q, drdata_d;

    logic              buf_load_s, buf_wr_s, buf_step_s, buf_clr_s, buf_last_s;
    logic [LINE_W-1:0] buf_line_nxt_s;
    logic [BEAT_W-1:0] buf_rd_beat_s;
    beat_idx_t         buf_idx_s, buf_rd_idx_s;
    logic              d_req_s;

    burst_line_buffer u_buf (
        .clk        (clk),
        .rst        (rst),
        .load_i     (buf_load_s),
        .line_i     (dcache_wdata),
        .wr_beat_i  (buf_wr_s),
        .beat_i     (pmem_rdata),
        .step_i     (buf_step_s),
        .clr_i      (buf_clr_s),
        .rd_idx_i   (buf_rd_idx_s),
        .line_nxt_o (buf_line_nxt_s),
        .rd_beat_o  (buf_rd_beat_s),
        .idx_o      (buf_idx_s),
        .last_o     (buf_last_s)
    );

    cache_mem_arbiter_checker u_chk (
        .clk          (clk),
        .rst          (rst),
        .dcache_read  (dcache_read),
        .dcache_write (dcache_write)
    );

    // Write bursts pre-fetch the slice after the one being accepted.
    assign buf_rd_idx_s = buf_idx_s + beat_idx_t'(1);
    assign d_req_s      = dcache_read | dcache_write;

    // Next-state and registered-output logic for the grant/burst sequence.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        pmem_read_d  = pmem_read_q;
        pmem_write_d = pmem_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        iresp_d      = 1'b0;
        dresp_d      = 1'b0;
        irdata_d     = irdata_q;
        drdata_d     = drdata_q;
        buf_load_s   = 1'b0;
        buf_wr_s     = 1'b0;
        buf_step_s   = 1'b0;
        buf_clr_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_req_s && (!icache_read || (last_grant_q == GRANT_I))) begin
                    grant_d    = GRANT_D;
                    addr_d     = line_align(dcache_address);
                    buf_load_s = 1'b1;
                    if (dcache_write) begin
                        state_d      = D_WR;
                        pmem_write_d = 1'b1;
                        wdata_d      = dcache_wdata[BEAT_W-1:0];
                    end else begin
                        state_d     = D_RD;
                        pmem_read_d = 1'b1;
                    end
                end else if (icache_read) begin
                    grant_d     = GRANT_I;
                    addr_d      = line_align(icache_address);
                    state_d     = I_RD;
                    pmem_read_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            I_RD, D_RD: begin
                if (pmem_resp) begin
                    buf_wr_s   = 1'b1;
                    buf_step_s = 1'b1;
                    if (buf_last_s) begin
                        state_d     = DONE;
                        pmem_read_d = 1'b0;
                        if (state_q == I_RD) begin
                            iresp_d  = 1'b1;
                            irdata_d = buf_line_nxt_s;
                        end else begin
                            dresp_d  = 1'b1;
                            drdata_d = buf_line_nxt_s;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            D_WR: begin
                if (pmem_resp) begin
                    buf_step_s = 1'b1;
                    if (buf_last_s) begin
                        state_d      = DONE;
                        pmem_write_d = 1'b0;
                        wdata_d      = '0;
                        dresp_d      = 1'b1;
                    end else begin
                        wdata_d = buf_rd_beat_s;
                    end
                end else begin
                    state_d = D_WR;
                end
            end
            DONE: begin
                last_grant_d = grant_q;
                buf_clr_s    = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                buf_clr_s    = 1'b1;
                pmem_read_d  = 1'b0;
                pmem_write_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    // State, arbitration history and all output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            grant_q      <= GRANT_I;
            last_grant_q <= GRANT_I;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            iresp_q      <= 1'b0;
            dresp_q      <= 1'b0;
            irdata_q     <= '0;
            drdata_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            iresp_q      <= iresp_d;
            dresp_q      <= dresp_d;
            irdata_q     <= irdata_d;
            drdata_q     <= drdata_d;
        end
    end

    assign icache_rdata = irdata_q;
    assign icache_resp  = iresp_q;
    assign dcache_rdata = drdata_q;
    assign dcache_resp  = dresp_q;
    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench: stimulus queues expected bursts/responses, a memory model
// and a response monitor pop and compare them.
module tb_cache_mem_arbiter;

    typedef struct {
        logic [31:0]  addr;
        bit           wr;
        logic [255:0] line;
        int           gap;
    } burst_t;

    typedef struct {
        bit           is_d;
        bit           wr;
        logic [255:0] line;
    } resp_t;

    logic         clk;
    logic         rst;
    logic         icache_read;
    logic [31:0]  icache_address;
    logic [255:0] icache_rdata;
    logic         icache_resp;
    logic         dcache_read;
    logic         dcache_write;
    logic [31:0]  dcache_address;
    logic [255:0] dcache_wdata;
    logic [255:0] dcache_rdata;
    logic         dcache_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [63:0]  pmem_wdata;
    logic [63:0]  pmem_rdata;
    logic         pmem_resp;

    burst_t bq[$];
    resp_t  rq[$];
    int     checks = 0;
    int     errors = 0;

    cache_mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .icache_read    (icache_read),
        .icache_address (icache_address),
        .icache_rdata   (icache_rdata),
        .icache_resp    (icache_resp),
        .dcache_read    (dcache_read),
        .dcache_write   (dcache_write),
        .dcache_address (dcache_address),
        .dcache_wdata   (dcache_wdata),
        .dcache_rdata   (dcache_rdata),
        .dcache_resp    (dcache_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mk_line(input logic [7:0] s);
        return {{8{s + 8'd3}}, {8{s + 8'd2}}, {8{s + 8'd1}}, {8{s}}};
    endfunction

    task automatic push(input bit is_d, input bit wr, input logic [31:0] addr,
                        input logic [255:0] line, input int gap);
        burst_t b;
        resp_t  r;
        b.addr = addr; b.wr = wr; b.line = line; b.gap = gap;
        r.is_d = is_d; r.wr = wr; r.line = line;
        bq.push_back(b);
        rq.push_back(r);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {pmem_read, pmem_write, icache_resp, dcache_resp, pmem_address,
                   pmem_wdata, icache_rdata | dcache_rdata}, '0);
    endtask

    // Wait until every raised request has received its resp; drop each on resp.
    task automatic serve(input int budget, output int lat);
        int n;
        n   = 0;
        lat = -1;
        while ((icache_read || dcache_read || dcache_write) && n < budget) begin
            @(negedge clk);
            n++;
            if ((icache_resp || dcache_resp) && lat < 0) lat = n;
            if (icache_resp) icache_read = 1'b0;
            if (dcache_resp) begin
                dcache_read  = 1'b0;
                dcache_write = 1'b0;
            end
        end
        chk("serve_done", 256'({icache_read, dcache_read, dcache_write}), 256'(0));
        icache_read  = 1'b0;
        dcache_read  = 1'b0;
        dcache_write = 1'b0;
    endtask

    // Burst memory model: checks address/direction/wdata, supplies read beats.
    initial begin
        burst_t e;
        int b, g, held;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst && (pmem_read || pmem_write)) begin
                if (bq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_burst actual=rd%0d/wr%0d required=none", pmem_read, pmem_write);
                    while (rst && (pmem_read || pmem_write)) @(negedge clk);
                end else begin
                    e = bq.pop_front();
                    chk("pmem_address", 256'(pmem_address), 256'(e.addr));
                    chk("pmem_dir_write", 256'(pmem_write), 256'(e.wr));
                    b = 0; g = 0; held = 0;
                    while (b < 4 && rst) begin
                        if (e.wr ? (pmem_write && !pmem_read) : (pmem_read && !pmem_write)) held++;
                        if (b > 0 && g < e.gap) begin
                            pmem_resp = 1'b0;
                            g++;
                            if (e.wr) chk("pmem_wdata_gap", 256'(pmem_wdata), 256'(e.line[b*64 +: 64]));
                        end else begin
                            pmem_resp  = 1'b1;
                            pmem_rdata = e.line[b*64 +: 64];
                            g = 0;
                            if (e.wr) chk("pmem_wdata_beat", 256'(pmem_wdata), 256'(e.line[b*64 +: 64]));
                            b++;
                        end
                        @(negedge clk);
                    end
                    pmem_resp = 1'b0;
                    if (rst) begin
                        chk("burst_held_cycles", 256'(held), 256'(4 + 3 * e.gap));
                        chk("burst_drop", 256'({pmem_read, pmem_write}), 256'(0));
                    end
                end
            end
        end
    end

    // Response monitor: every resp cycle must match the next queued response.
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (icache_resp || dcache_resp) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp actual=i%0d/d%0d required=none", icache_resp, dcache_resp);
                end else begin
                    r = rq.pop_front();
                    chk("resp_port", 256'({icache_resp, dcache_resp}), r.is_d ? 256'(2'b01) : 256'(2'b10));
                    if (!r.wr) chk("resp_rdata", r.is_d ? dcache_rdata : icache_rdata, r.line);
                end
            end
        end
    end

    initial begin
        logic [255:0] l1, lw;
        int lat, n, i_left, d_left;
        bit ri, rd;
        rst = 1'b0;
        icache_read = 1'b0; icache_address = '0;
        dcache_read = 1'b0; dcache_write = 1'b0;
        dcache_address = '0; dcache_wdata = '0;
        l1 = 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;
        lw = 256'hDDDDDDDDDDDDDDDD_CCCCCCCCCCCCCCCC_BBBBBBBBBBBBBBBB_AAAAAAAAAAAAAAAA;

        repeat (3) @(negedge clk);
        chk_all_zero("reset_outputs");
        rst = 1'b1;
        @(negedge clk);

        // I read only, zero-gap memory.
        push(1'b0, 1'b0, 32'h0000_1220, l1, 0);
        icache_address = 32'h0000_1234;
        icache_read    = 1'b1;
        serve(40, lat);
        chk("i_latency", 256'(lat), 256'(5));
        repeat (3) @(negedge clk);
        chk("icache_rdata_hold", icache_rdata, l1);
        chk("dcache_rdata_idle", dcache_rdata, '0);

        // D writeback with 2-cycle gaps; cache inputs change after grant.
        push(1'b1, 1'b1, 32'h8000_0040, lw, 2);
        dcache_address = 32'h8000_0040;
        dcache_wdata   = lw;
        dcache_write   = 1'b1;
        repeat (2) @(negedge clk);
        dcache_wdata   = ~lw;
        dcache_address = 32'hFFFF_FFFF;
        serve(60, lat);
        chk("icache_rdata_hold2", icache_rdata, l1);

        // Simultaneous I and D reads right after reset: D first.
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        push(1'b1, 1'b0, 32'h0000_2000, mk_line(8'h50), 0);
        push(1'b0, 1'b0, 32'h0000_3000, mk_line(8'h30), 1);
        dcache_address = 32'h0000_2000; dcache_read = 1'b1;
        icache_address = 32'h0000_3010; icache_read = 1'b1;
        serve(80, lat);

        // Both re-request continuously: D, I, D, I.
        push(1'b1, 1'b0, 32'h4000_0100, mk_line(8'hA0), 0);
        push(1'b0, 1'b0, 32'h0000_0480, mk_line(8'hB0), 0);
        push(1'b1, 1'b0, 32'h4000_0120, mk_line(8'hC0), 1);
        push(1'b0, 1'b0, 32'h0000_04A0, mk_line(8'hD0), 0);
        dcache_address = 32'h4000_0100; dcache_read = 1'b1;
        icache_address = 32'h0000_0480; icache_read = 1'b1;
        i_left = 2; d_left = 2; ri = 1'b0; rd = 1'b0; n = 0;
        while ((i_left > 0 || d_left > 0) && n < 200) begin
            @(negedge clk);
            n++;
            if (ri) begin icache_address = 32'h0000_04A5; icache_read = 1'b1; ri = 1'b0; end
            if (rd) begin dcache_address = 32'h4000_013F; dcache_read = 1'b1; rd = 1'b0; end
            if (icache_resp) begin icache_read = 1'b0; i_left--; ri = (i_left > 0); end
            if (dcache_resp) begin dcache_read = 1'b0; d_left--; rd = (d_left > 0); end
        end
        chk("alternate_done", 256'({i_left[7:0], d_left[7:0]}), 256'(0));
        icache_read = 1'b0; dcache_read = 1'b0;

        // Reset after beat 2 of a D read: outputs clear, no resp.
        bq.push_back('{addr: 32'h0000_7000, wr: 1'b0, line: mk_line(8'h60), gap: 0});
        dcache_address = 32'h0000_7000; dcache_read = 1'b1;
        n = 0; lat = 0;
        while (lat < 2 && n < 50) begin
            @(posedge clk);
            n++;
            if (pmem_resp && pmem_read) lat++;
        end
        chk("beats_before_reset", 256'(lat), 256'(2));
        #2 rst = 1'b0;
        dcache_read = 1'b0;
        #1 chk_all_zero("async_reset_outputs");
        repeat (2) @(negedge clk);
        chk_all_zero("held_reset_outputs");
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("no_resp_after_abort", 256'({icache_resp, dcache_resp, pmem_read}), 256'(0));
        end
        push(1'b0, 1'b0, 32'h0000_5000, mk_line(8'h70), 1);
        icache_address = 32'h0000_5008; icache_read = 1'b1;
        serve(60, lat);

        // Illegal read+write: the writeback is performed.
        push(1'b1, 1'b1, 32'h0000_6040, mk_line(8'h90), 1);
        dcache_address = 32'h0000_6044;
        dcache_wdata   = mk_line(8'h90);
        dcache_read    = 1'b1;
        dcache_write   = 1'b1;
        serve(60, lat);

        repeat (4) @(negedge clk);
        chk("resp_queue_empty", 256'(rq.size()), 256'(0));
        chk("burst_queue_empty", 256'(bq.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
